// File: rtl/sqrt_rr_sched_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module      : sqrt_rr_sched_if
// Description : Requester bus and sqrt-engine control bundle for the
//               round-robin sqrt scheduler. The scheduler takes the slave
//               view; requesters and the engine together take the master view.
// Revision    : 1.0 - initial release
// ---------------------------------------------------------------------------
interface sqrt_rr_sched_if #(
  parameter int NREQ = 4,
  parameter int DW   = 16,
  parameter int RW   = 8
);
  // requester side
  logic [NREQ-1:0]    req;
  logic [NREQ*DW-1:0] req_a;
  logic [NREQ-1:0]    ack;
  logic [RW-1:0]      rsp_data;
  logic               rsp_err;
  logic               busy;
  // engine side
  logic               eng_clr;
  logic               eng_go;
  logic [DW-1:0]      eng_a;
  logic               eng_done;
  logic [RW-1:0]      eng_result;

  modport slave (
    input  req, req_a, eng_done, eng_result,
    output ack, rsp_data, rsp_err, busy, eng_clr, eng_go, eng_a
  );

  modport master (
    output req, req_a, eng_done, eng_result,
    input  ack, rsp_data, rsp_err, busy, eng_clr, eng_go, eng_a
  );
endinterface
`default_nettype wire

// File: rtl/sqrt_rr_sched.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module      : sqrt_rr_sched
// Description : Round-robin scheduler sharing one iterative square-root
//               engine among NREQ requesters. Clears and launches the engine,
//               waits for its done level (with timeout), then returns the
//               root to the granted requester with a one-cycle ack.
// Revision    : 1.0 - initial release
// ---------------------------------------------------------------------------
module sqrt_rr_sched #(
  parameter int NREQ    = 4,
  parameter int DW      = 16,
  parameter int RW      = 8,
  parameter int TOW     = 10,
  parameter int TIMEOUT = 1023
) (
  input  logic             clk,
  input  logic             clr,
  sqrt_rr_sched_if.slave   bus
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam logic [IW:0] NREQ_W = (IW+1)'(NREQ);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    CLRE   = 3'd1,
    LAUNCH = 3'd2,
    WAIT   = 3'd3,
    RESP   = 3'd4
  } state_t;

  state_t           state_q;
  logic [IW-1:0]    last_gnt_q;
  logic [IW-1:0]    gnt_id_q;
  logic [TOW-1:0]   cnt_q;
  logic [NREQ-1:0]  ack_q;
  logic [RW-1:0]    rsp_data_q;
  logic             rsp_err_q;
  logic             busy_q;
  logic             eng_clr_q;
  logic             eng_go_q;
  logic [DW-1:0]    eng_a_q;

  logic             gnt_vld_d;
  logic [IW-1:0]    gnt_id_d;
  logic [IW:0]      cand;
  logic [DW-1:0]    op_d;
  logic [TOW-1:0]   cnt_inc;
  logic             timeout_hit;

  // The counter value this WAIT cycle will be after incrementing; the job
  // times out when that reaches TIMEOUT, so WAIT lasts TIMEOUT cycles.
  assign cnt_inc     = cnt_q + TOW'(1);
  assign timeout_hit = (cnt_inc == TOW'(TIMEOUT));

  // Round-robin pick: first pending requester after last_gnt, with wrap.
  // Scanning from the farthest candidate down lets the nearest one win.
  always_comb begin
    gnt_vld_d = 1'b0;
    gnt_id_d  = '0;
    cand      = '0;
    for (int k = NREQ; k >= 1; k--) begin
      cand = {1'b0, last_gnt_q} + (IW+1)'(k);
      if (cand >= NREQ_W) cand = cand - NREQ_W;
      if (bus.req[cand[IW-1:0]]) begin
        gnt_vld_d = 1'b1;
        gnt_id_d  = cand[IW-1:0];
      end
    end
  end

  // Select the granted requester's operand for latching into eng_a.
  always_comb begin
    op_d = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (gnt_id_d == IW'(i)) op_d = bus.req_a[i*DW +: DW];
    end
  end

  // Control FSM with all outputs registered; clr aborts any job at once.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state_q    <= IDLE;
      last_gnt_q <= IW'(NREQ-1);
      gnt_id_q   <= '0;
      cnt_q      <= '0;
      ack_q      <= '0;
      rsp_data_q <= '0;
      rsp_err_q  <= 1'b0;
      busy_q     <= 1'b0;
      eng_clr_q  <= 1'b0;
      eng_go_q   <= 1'b0;
      eng_a_q    <= '0;
    end else begin
      ack_q     <= '0;
      eng_clr_q <= 1'b0;
      eng_go_q  <= 1'b0;
      case (state_q)
        IDLE: begin
          if (gnt_vld_d) begin
            gnt_id_q   <= gnt_id_d;
            last_gnt_q <= gnt_id_d;
            eng_a_q    <= op_d;
            eng_clr_q  <= 1'b1;
            busy_q     <= 1'b1;
            state_q    <= CLRE;
          end
        end
        CLRE: begin
          eng_go_q <= 1'b1;
          state_q  <= LAUNCH;
        end
        LAUNCH: begin
          cnt_q   <= '0;
          state_q <= WAIT;
        end
        WAIT: begin
          cnt_q <= cnt_inc;
          if (bus.eng_done) begin
            rsp_data_q <= bus.eng_result;
            rsp_err_q  <= 1'b0;
            ack_q      <= NREQ'(1) << gnt_id_q;
            state_q    <= RESP;
          end else if (timeout_hit) begin
            rsp_data_q <= '0;
            rsp_err_q  <= 1'b1;
            ack_q      <= NREQ'(1) << gnt_id_q;
            state_q    <= RESP;
          end
        end
        RESP: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign bus.ack      = ack_q;
  assign bus.rsp_data = rsp_data_q;
  assign bus.rsp_err  = rsp_err_q;
  assign bus.busy     = busy_q;
  assign bus.eng_clr  = eng_clr_q;
  assign bus.eng_go   = eng_go_q;
  assign bus.eng_a    = eng_a_q;

endmodule
`default_nettype wire

// File: tb/tb_sqrt_rr_sched.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module      : tb_sqrt_rr_sched
// Description : Scoreboard bench for sqrt_rr_sched with a behavioural
//               sqrt engine that can be forced to stall.
// Revision    : 1.0 - initial release
// ---------------------------------------------------------------------------
module tb_sqrt_rr_sched;
  localparam int NREQ = 4;
  localparam int DW   = 16;
  localparam int RW   = 8;

  typedef struct {
    int id;
    int op;
    int res;
    bit err;
  } exp_t;

  logic clk = 1'b0;
  logic clr = 1'b1;
  logic [NREQ-1:0]    req_v = '0;
  logic [NREQ*DW-1:0] a_v   = '0;
  logic               m_done = 1'b0;
  logic [RW-1:0]      m_res  = '0;
  bit                 stuck  = 1'b0;
  int                 e_cnt  = 0;
  bit                 e_run  = 1'b0;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  logic prev_clr = 1'b0;

  always #5 clk = ~clk;

  sqrt_rr_sched_if #(.NREQ(NREQ), .DW(DW), .RW(RW)) bus ();

  assign bus.req        = req_v;
  assign bus.req_a      = a_v;
  assign bus.eng_done   = m_done;
  assign bus.eng_result = m_res;

  sqrt_rr_sched #(.NREQ(NREQ), .DW(DW), .RW(RW), .TOW(10), .TIMEOUT(1023)) dut (
    .clk (clk),
    .clr (clr),
    .bus (bus)
  );

  function automatic logic [RW-1:0] isqrt(input logic [DW-1:0] x);
    int r = 0;
    while ((r + 1) * (r + 1) <= int'(x)) r++;
    return RW'(r);
  endfunction

  // Engine model: clear stops it, go starts it, done rises after a short
  // operand-dependent delay and stays high until the next clear.
  always @(posedge clk) begin
    if (bus.eng_clr) begin
      e_run  <= 1'b0;
      m_done <= 1'b0;
    end else if (bus.eng_go) begin
      e_run  <= 1'b1;
      e_cnt  <= 3 + int'(bus.eng_a[2:0]);
      m_res  <= isqrt(bus.eng_a);
      m_done <= 1'b0;
    end else if (e_run && !stuck) begin
      if (e_cnt == 0) begin
        m_done <= 1'b1;
        e_run  <= 1'b0;
      end else begin
        e_cnt <= e_cnt - 1;
      end
    end
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, want);
    end
  endtask

  task automatic issue(input int id, input int op, input int res, input bit err);
    exp_t e;
    e.id = id; e.op = op; e.res = res; e.err = err;
    a_v[id*DW +: DW] = DW'(op);
    req_v[id] = 1'b1;
    exp_q.push_back(e);
  endtask

  task automatic drain(input int max);
    int n = 0;
    while ((exp_q.size() != 0 || bus.busy) && n < max) begin
      @(negedge clk);
      n++;
    end
    if (exp_q.size() != 0 || bus.busy) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: %0d jobs still pending after %0d cycles", exp_q.size(), max);
      exp_q.delete();
      req_v = '0;
    end
    @(negedge clk);
  endtask

  task automatic wait_go(input int max);
    int n = 0;
    while (!bus.eng_go && n < max) begin
      @(negedge clk);
      n++;
    end
    if (!bus.eng_go) begin
      checks++;
      errors++;
      $display("FAIL wait_go_timeout: eng_go not seen within %0d cycles", max);
    end
  endtask

  // Requesters drop req as soon as they observe their ack.
  initial begin
    forever begin
      @(negedge clk);
      for (int i = 0; i < NREQ; i++) if (bus.ack[i]) req_v[i] = 1'b0;
    end
  end

  // Monitor: checks launch ordering/operand and pops one expectation per ack.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (bus.eng_go) begin
        chk("go_after_clr", 64'(prev_clr), 64'd1);
        if (exp_q.size() != 0) chk("eng_a", 64'(bus.eng_a), 64'(exp_q[0].op));
      end
      if (bus.ack != '0) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_ack: got ack 0x%0h expected none", bus.ack);
        end else begin
          e = exp_q.pop_front();
          chk("ack_id", 64'(bus.ack), 64'(NREQ'(1) << e.id));
          chk("rsp_data", 64'(bus.rsp_data), 64'(e.res));
          chk("rsp_err", 64'(bus.rsp_err), 64'(e.err));
          chk("busy_in_resp", 64'(bus.busy), 64'd1);
        end
      end
      prev_clr = bus.eng_clr;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete, got hang expected finish");
    $fatal(1, "watchdog");
  end

  task automatic do_reset();
    @(negedge clk);
    clr = 1'b1;
    repeat (2) @(negedge clk);
    clr = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    int n;
    // Reset values
    repeat (2) @(negedge clk);
    chk("reset_outs", 64'({bus.ack, bus.rsp_data, bus.rsp_err, bus.busy,
                           bus.eng_clr, bus.eng_go, bus.eng_a}), 64'd0);
    clr = 1'b0;
    @(negedge clk);

    // 1. Single request
    issue(0, 144, 12, 1'b0);
    @(negedge clk);
    chk("busy_after_grant", 64'(bus.busy), 64'd1);
    chk("clr_pulse", 64'(bus.eng_clr), 64'd1);
    @(negedge clk);
    chk("go_pulse", 64'(bus.eng_go), 64'd1);
    chk("clr_one_cycle", 64'(bus.eng_clr), 64'd0);
    drain(200);

    // 2. Contention after reset: 0,1,2,3
    do_reset();
    issue(0, 1, 1, 1'b0);
    issue(1, 100, 10, 1'b0);
    issue(2, 1000, 31, 1'b0);
    issue(3, 50000, 223, 1'b0);
    drain(400);

    // 3. Fairness: serve 1, then 0101 -> 2 before 0
    issue(1, 49, 7, 1'b0);
    drain(200);
    issue(2, 81, 9, 1'b0);
    issue(0, 16, 4, 1'b0);
    drain(300);

    // 4. Boundaries
    issue(0, 0, 0, 1'b0);
    drain(200);
    issue(1, 65535, 255, 1'b0);
    issue(2, 65025, 255, 1'b0);
    drain(300);

    // 5. Timeout, then recovery
    stuck = 1'b1;
    issue(3, 144, 0, 1'b1);
    wait_go(20);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (bus.ack == '0 && n < 2000);
    chk("timeout_go_to_ack", 64'(n), 64'd1024);
    drain(50);
    stuck = 1'b0;
    issue(0, 1000, 31, 1'b0);
    drain(200);

    // 6. Reset mid-WAIT while serving requester 2
    stuck = 1'b1;
    issue(2, 65025, 255, 1'b0);
    wait_go(20);
    repeat (10) @(negedge clk);
    clr = 1'b1;
    #1;
    chk("abort_outs", 64'({bus.ack, bus.rsp_data, bus.rsp_err, bus.busy,
                           bus.eng_clr, bus.eng_go, bus.eng_a}), 64'd0);
    stuck = 1'b0;
    repeat (2) @(negedge clk);
    clr = 1'b0;
    drain(200);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/sqrt_rr_sched.md
Name: sqrt_rr_sched

Overview:
- Round-robin scheduler that shares one iterative square-root engine among NREQ requesters in the Normalization V2 datapath.
- The engine is the existing go/clr-controlled subtractive sqrt unit, whose control FSM parks in a terminal done state until cleared.
- This block owns the engine's clear, go and operand inputs, captures its result, and returns the result to the granted requester with a one-cycle ack.

Parameters:
- NREQ, 4, number of requesters (2..8).
- DW, 16, operand width.
- RW, 8, result width (DW/2).
- TOW, 10, timeout counter width.
- TIMEOUT, 1023, maximum WAIT cycles before abort (must be less than 2^TOW).

Ports:
- clk  in  1  clock
- clr  in  1  reset, asynchronous, active-high
- req  in  NREQ  per-requester request level, held until ack
- req_a  in  NREQ*DW  operands, requester i at bits [i*DW +: DW]
- ack  out  NREQ  one-hot, one-cycle completion pulse
- rsp_data  out  RW  result, valid while any ack bit is high
- rsp_err  out  1  timeout flag, valid with ack
- busy  out  1  high in every state except IDLE
- eng_clr  out  1  engine clear pulse
- eng_go  out  1  engine start pulse
- eng_a  out  DW  engine operand
- eng_done  in  1  engine output-load level (high in engine done state)
- eng_result  in  RW  engine root value

Behaviour:
- All outputs are registered.
- Reset values: ack=0, rsp_data=0, rsp_err=0, busy=0, eng_clr=0, eng_go=0, eng_a=0, state=IDLE, timeout counter=0. The pointer last_gnt resets to NREQ-1, so requester 0 has highest priority first.
- Asserting clr in any state aborts immediately. No ack is issued for the aborted job; its requester stays pending and is re-arbitrated after reset.
- IDLE:
  - If any req bit is high, grant the first set bit searching upward from last_gnt+1 with wrap.
  - Latch gnt_id and the requester's operand into eng_a. Update last_gnt to gnt_id. Go to CLRE.
  - If no req bit is high, stay in IDLE.
- CLRE: eng_clr=1 for exactly one cycle, forcing the engine to its start state. Go to LAUNCH.
- LAUNCH: eng_go=1 for exactly one cycle. Clear the counter. Go to WAIT.
- WAIT:
  - Counter increments each cycle.
  - If eng_done=1, capture eng_result into rsp_data, set rsp_err=0, go to RESP.
  - Else if counter==TIMEOUT, set rsp_data=0, set rsp_err=1, go to RESP.
  - If eng_done and the timeout condition occur in the same cycle, eng_done wins.
- RESP: ack[gnt_id]=1 for one cycle, with rsp_data and rsp_err stable in that cycle. Go to IDLE.
- Requester handshake: a requester must drop req in the cycle after it sees ack. A req still high when IDLE samples it is treated as a new request. IDLE then next arbitrates one cycle after RESP.
- eng_a holds the latched operand from grant until the next grant. Changes on req_a after grant are ignored.
- Requests arriving or dropping while busy do not affect the current job. Dropping req before ack is illegal; the job still completes and still acks.
- Job latency from grant cycle to ack cycle is 4 + W cycles, where W is the number of cycles spent in WAIT.
- Timeout: with TIMEOUT=1023, an eng_done stuck low produces ack with rsp_err=1 exactly 1023 cycles after entering WAIT.
- Round robin guarantees that any pending requester is served within NREQ-1 other jobs.
- Only one ack bit is ever high in a cycle; outside RESP, ack is all zeros.

Test Plan:
1. Single request: req=0001, req_a[0]=144, engine model returns 12 -> eng_clr pulse, then eng_go pulse, then ack=0001 with rsp_data=12 and rsp_err=0. busy is high from the cycle after grant through RESP.
2. Contention: req=1111 after reset, all held until ack -> ack order 0,1,2,3; each job sees its own operand on eng_a; each rsp_data matches that requester's sqrt.
3. Fairness: last served requester is 1, req=0101 -> requester 2 acked before requester 0.
4. Boundaries: operand 0 -> result 0; operand 65535 -> result 255; operand 65025 -> result 255. No timeout in any case with the real engine model.
5. Timeout: engine model never raises eng_done -> ack with rsp_err=1 and rsp_data=0 after 1023 WAIT cycles. The next grant still produces eng_clr then eng_go, and the engine recovers.
6. Reset mid-WAIT: assert clr while serving requester 2 -> all outputs 0 on the same edge, no ack. After release with req=0100 still held, requester 2 is re-granted and completes.
